// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register feeding a 2-entry {pc, inst} buffer toward decode,
// with redirect, out-of-range fault stop, and synchronous active-high reset.
module instruction_fetch #(
    parameter int          IMEM_BYTES = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] addrIM,
    input  logic [31:0] inst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pc4,
    output logic        fetch_fault,
    output logic [1:0]  occupancy
);

    // state | meaning
    // RUN   | fetching while the buffer has room and the PC is in range
    // FAULT | PC left the memory; no fetches, buffered entries still drain
    typedef enum logic {RUN, FAULT} state_t;

    localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic [31:0] fifo_pc   [2];
    logic [31:0] fifo_inst [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;
    logic        pop, fetch_req, in_range, push;

    assign addrIM      = pc;
    assign occupancy   = count;
    assign dec_valid   = (count != 2'd0) && !redirect && !rst;
    assign dec_pc      = fifo_pc[rd_ptr];
    assign dec_inst    = fifo_inst[rd_ptr];
    assign dec_pc4     = fifo_pc[rd_ptr] + 32'd4;
    assign fetch_fault = (state == FAULT) && !rst;

    assign pop       = dec_valid && dec_ready;
    assign fetch_req = (state == RUN) && ((count != 2'd2) || pop);
    assign in_range  = (pc <= LAST_ADDR);
    assign push      = fetch_req && in_range && !redirect && !rst;

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (redirect)
            state_nxt = RUN;
        else if (fetch_req && !in_range)
            state_nxt = FAULT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= {RESET_PC[31:2], 2'b00};
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (redirect) begin
            pc     <= {redirect_pc[31:2], 2'b00};
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // When full with a simultaneous pop, wr_ptr equals rd_ptr: the slot being
    // refilled is the head that leaves this same edge, so nothing live is lost.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= pc;
            fifo_inst[wr_ptr] <= inst;
        end
    end

endmodule
